// File: rtl/cce_ob_mon_pkg.sv
// Shared constants and types for the CCE outbound length monitor.
//   TUSER_*           : frame marker values carried on ob_tuser
//   DATA_TYPE_DEFAULT : tdata[7:0] of an SoT beat that opens a compressed-data frame
//   state_e           : monitor FSM states
package cce_ob_mon_pkg;

    localparam logic [7:0] TUSER_MID     = 8'h00;
    localparam logic [7:0] TUSER_SOT     = 8'h01;
    localparam logic [7:0] TUSER_EOT     = 8'h02;
    localparam logic [7:0] TUSER_SOT_EOT = 8'h03;

    localparam logic [7:0] DATA_TYPE_DEFAULT = 8'h05;

    localparam int unsigned STRB_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/cce_strb_popcnt.sv
// Counts the set bits of a beat's byte strobes; strobes need not be contiguous.
//   i_strb   : byte-valid strobes
//   o_cnt_c  : number of set strobe bits (combinational)
module cce_strb_popcnt
    import cce_ob_mon_pkg::*;
(
    input  logic [STRB_W-1:0] i_strb,
    output logic [CNT_W-1:0]  o_cnt_c
);

    always_comb begin
        o_cnt_c = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            o_cnt_c = o_cnt_c + CNT_W'(i_strb[i]);
        end
    end

endmodule

// File: rtl/cce_ob_len_monitor.sv
// Consumes the CCE engine outbound stream, finds compressed-data frames and
// reports their payload byte count on a result handshake.
//   clk, rst            : clock, synchronous active-high reset
//   ob_*                : outbound AXI-stream from the engine (tlast/tid ignored)
//   len_tvalid/tready   : result handshake
//   len_tdata, len_err  : payload byte count and restart/saturation flag
//   frame_cnt           : results delivered since reset (wrapping)
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 8
`endif

module cce_ob_len_monitor
    import cce_ob_mon_pkg::*;
#(
    parameter logic [7:0]  DATA_TYPE = DATA_TYPE_DEFAULT,
    parameter int unsigned LEN_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ob_tvalid,
    output logic                         ob_tready,
    input  logic [63:0]                  ob_tdata,
    input  logic [7:0]                   ob_tstrb,
    input  logic [7:0]                   ob_tuser,
    input  logic                         ob_tlast,
    input  logic [`AXI_S_TID_WIDTH-1:0]  ob_tid,
    output logic                         len_tvalid,
    input  logic                         len_tready,
    output logic [LEN_W-1:0]             len_tdata,
    output logic                         len_err,
    output logic [FCNT_W-1:0]            frame_cnt
);

    localparam int unsigned SUM_W = LEN_W + 1;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    w_count_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic [FCNT_W-1:0]   w_frame_cnt_nxt;
    logic                r_tready;
    logic                r_len_tvalid;

    logic [CNT_W-1:0]    w_pop;
    logic                w_acc;
    logic                w_hdr;
    logic [SUM_W-1:0]    w_sum;
    logic [LEN_W-1:0]    w_sat_count;
    logic                w_ovf;

    // Framing relies on tuser only; the upper data bytes, tlast and tid are don't-care.
    logic                w_unused;
    assign w_unused = ^{ob_tlast, ob_tid, ob_tdata[63:8]};

    cce_strb_popcnt u_popcnt (
        .i_strb  (ob_tstrb),
        .o_cnt_c (w_pop)
    );

    assign w_acc = ob_tvalid & r_tready;
    assign w_hdr = (ob_tdata[7:0] == DATA_TYPE);

    // Saturating add: the carry out of the widened sum flags overflow.
    assign w_sum       = {1'b0, r_count} + SUM_W'(w_pop);
    assign w_ovf       = w_sum[LEN_W];
    assign w_sat_count = w_ovf ? '1 : w_sum[LEN_W-1:0];

    // Next-state and next-value logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_err_nxt       = r_err;
        w_frame_cnt_nxt = r_frame_cnt;
        case (r_state)
            IDLE: begin
                if (w_acc && w_hdr) begin
                    if (ob_tuser == TUSER_SOT) begin
                        w_state_nxt = DATA;
                        w_count_nxt = '0;
                        w_err_nxt   = 1'b0;
                    end else if (ob_tuser == TUSER_SOT_EOT) begin
                        w_state_nxt = RESULT;
                        w_count_nxt = '0;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            DATA: begin
                if (w_acc) begin
                    case (ob_tuser)
                        // A new SoT of any type restarts the frame; its header is not counted.
                        TUSER_SOT: begin
                            w_count_nxt = '0;
                            w_err_nxt   = 1'b1;
                        end
                        TUSER_SOT_EOT: begin
                            w_count_nxt = '0;
                            w_err_nxt   = 1'b1;
                            w_state_nxt = RESULT;
                        end
                        TUSER_EOT: begin
                            w_count_nxt = w_sat_count;
                            w_err_nxt   = r_err | w_ovf;
                            w_state_nxt = RESULT;
                        end
                        default: begin
                            w_count_nxt = w_sat_count;
                            w_err_nxt   = r_err | w_ovf;
                        end
                    endcase
                end
            end
            RESULT: begin
                if (len_tready) begin
                    w_state_nxt     = IDLE;
                    w_frame_cnt_nxt = r_frame_cnt + FCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; handshake outputs are pre-decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_frame_cnt  <= '0;
            r_tready     <= 1'b0;
            r_len_tvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_err        <= w_err_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_tready     <= (w_state_nxt != RESULT);
            r_len_tvalid <= (w_state_nxt == RESULT);
        end
    end

    assign ob_tready  = r_tready;
    assign len_tvalid = r_len_tvalid;
    assign len_tdata  = r_count;
    assign len_err    = r_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_cce_ob_len_monitor.sv
// Self-checking bench for cce_ob_len_monitor: table-driven frames, directed
// corner sequences, then a random beat stream against a frame-level model.
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 8
`endif

module tb_cce_ob_len_monitor;
    import cce_ob_mon_pkg::*;

    localparam int TIDW = `AXI_S_TID_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic            ob_tvalid;
    logic [63:0]     ob_tdata;
    logic [7:0]      ob_tstrb;
    logic [7:0]      ob_tuser;
    logic            ob_tlast;
    logic [TIDW-1:0] ob_tid;
    logic            len_tready;

    logic            ob_tready, len_tvalid, len_err;
    logic [31:0]     len_tdata;
    logic [15:0]     frame_cnt;

    logic            s_ob_tready, s_len_tvalid, s_len_err;
    logic [3:0]      s_len_tdata;
    logic [15:0]     s_frame_cnt;

    always #5 clk = ~clk;

    cce_ob_len_monitor u_dut (
        .clk(clk), .rst(rst),
        .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
        .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tlast(ob_tlast), .ob_tid(ob_tid),
        .len_tvalid(len_tvalid), .len_tready(len_tready), .len_tdata(len_tdata),
        .len_err(len_err), .frame_cnt(frame_cnt)
    );

    // Narrow counter instance to reach saturation with short frames.
    cce_ob_len_monitor #(.LEN_W(4)) u_dut_sat (
        .clk(clk), .rst(rst),
        .ob_tvalid(ob_tvalid), .ob_tready(s_ob_tready), .ob_tdata(ob_tdata),
        .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tlast(ob_tlast), .ob_tid(ob_tid),
        .len_tvalid(s_len_tvalid), .len_tready(len_tready), .len_tdata(s_len_tdata),
        .len_err(s_len_err), .frame_cnt(s_frame_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int exp_fc = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst && len_tvalid && len_tready) got_q.push_back({len_err, len_tdata});
    end

    typedef struct {
        logic [3:0][7:0] strb;
        int              nb;
        logic [31:0]     len;
    } vec_t;
    vec_t tbl[7];

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic [7:0]  u;
    } beat_t;
    beat_t bq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] lo);
        logic [63:0] d;
        d      = {$urandom, $urandom};
        d[7:0] = lo;
        return d;
    endfunction

    task automatic idle();
        ob_tvalid = 1'b0;
    endtask

    // Present a beat and hold it until the monitor accepts it; returns just after the accepting edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic [7:0] u);
        bit acc;
        int waited;
        acc       = 1'b0;
        waited    = 0;
        ob_tvalid = 1'b1;
        ob_tdata  = d;
        ob_tstrb  = s;
        ob_tuser  = u;
        ob_tlast  = (u == TUSER_EOT) || (u == TUSER_SOT_EOT);
        ob_tid    = TIDW'($urandom);
        while (!acc && waited < 300) begin
            acc = ob_tready;
            tick();
            waited++;
        end
        if (!acc) chk("beat_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_result();
        int w;
        w = 0;
        while (!len_tvalid && w < 300) begin
            tick();
            w++;
        end
        if (!len_tvalid) chk("result_timeout", 64'd0, 64'd1);
    endtask

    task automatic set_vec(input int i, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3,
                           input int nb, input logic [31:0] len);
        tbl[i].strb = {s3, s2, s1, s0};
        tbl[i].nb   = nb;
        tbl[i].len  = len;
    endtask

    // Frame-level reference: walks the accepted beat list and lists the results it must yield.
    task automatic model();
        bit in_f;
        bit e;
        int cnt;
        in_f = 1'b0;
        e    = 1'b0;
        cnt  = 0;
        exp_q.delete();
        foreach (bq[i]) begin
            if (!in_f) begin
                if (bq[i].d[7:0] == 8'h05 && bq[i].u == TUSER_SOT) begin
                    in_f = 1'b1; cnt = 0; e = 1'b0;
                end else if (bq[i].d[7:0] == 8'h05 && bq[i].u == TUSER_SOT_EOT) begin
                    exp_q.push_back({1'b0, 32'd0});
                end
            end else if (bq[i].u == TUSER_SOT) begin
                cnt = 0; e = 1'b1;
            end else if (bq[i].u == TUSER_SOT_EOT) begin
                exp_q.push_back({1'b1, 32'd0});
                in_f = 1'b0;
            end else begin
                cnt = cnt + $countones(bq[i].s);
                if (bq[i].u == TUSER_EOT) begin
                    exp_q.push_back({e, 32'(cnt)});
                    in_f = 1'b0;
                end
            end
        end
    endtask

    task automatic push_mids(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = mk(8'($urandom)); b.s = 8'($urandom); b.u = TUSER_MID;
            bq.push_back(b);
        end
    endtask

    task automatic push_beat(input logic [7:0] lo, input logic [7:0] s, input logic [7:0] u);
        beat_t b;
        b.d = mk(lo); b.s = s; b.u = u;
        bq.push_back(b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        bit rnd_done;
        logic [3:0] exp_s;

        rst = 1'b1; ob_tvalid = 1'b0; ob_tdata = '0; ob_tstrb = '0; ob_tuser = '0;
        ob_tlast = 1'b0; ob_tid = '0; len_tready = 1'b1;

        set_vec(0, 8'hff, 8'hff, 8'hff, 8'h0f, 4, 32'd28);
        set_vec(1, 8'ha5, 8'ha5, 8'ha5, 8'ha5, 4, 32'd16);
        set_vec(2, 8'hff, 8'hff, 8'h00, 8'h00, 2, 32'd16);
        set_vec(3, 8'h00, 8'h00, 8'h00, 8'h00, 1, 32'd0);
        set_vec(4, 8'h80, 8'h01, 8'h3c, 8'h00, 3, 32'd6);
        set_vec(5, 8'hff, 8'hfe, 8'h7f, 8'h55, 4, 32'd26);
        set_vec(6, 8'hff, 8'h7f, 8'h00, 8'h00, 2, 32'd15);

        // Reset state.
        tick();
        chk("rst_tready", 64'(ob_tready), 64'd0);
        chk("rst_len_tvalid", 64'(len_tvalid), 64'd0);
        chk("rst_len_tdata", 64'(len_tdata), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        tick();
        chk("rst_tready_hold", 64'(ob_tready), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_tready", 64'(ob_tready), 64'd1);

        // Table of single frames: header, then payload beats ending in EoT.
        for (int k = 0; k < 7; k++) begin
            len_tready = 1'b1;
            send_beat(mk(8'h05), 8'hff, TUSER_SOT);
            for (int b = 0; b < tbl[k].nb; b++)
                send_beat(mk(8'($urandom)), tbl[k].strb[b], (b == tbl[k].nb - 1) ? TUSER_EOT : TUSER_MID);
            idle();
            exp_s = (tbl[k].len > 32'd15) ? 4'hf : 4'(tbl[k].len);
            chk($sformatf("tbl%0d_valid", k), 64'(len_tvalid), 64'd1);
            chk($sformatf("tbl%0d_tready", k), 64'(ob_tready), 64'd0);
            chk($sformatf("tbl%0d_len", k), 64'(len_tdata), 64'(tbl[k].len));
            chk($sformatf("tbl%0d_err", k), 64'(len_err), 64'd0);
            chk($sformatf("tbl%0d_sat_len", k), 64'(s_len_tdata), 64'(exp_s));
            chk($sformatf("tbl%0d_sat_err", k), 64'(s_len_err), 64'(tbl[k].len > 32'd15));
            tick();
            exp_fc++;
            chk($sformatf("tbl%0d_valid_drop", k), 64'(len_tvalid), 64'd0);
            chk($sformatf("tbl%0d_tready_back", k), 64'(ob_tready), 64'd1);
            chk($sformatf("tbl%0d_frame_cnt", k), 64'(frame_cnt), 64'(exp_fc));
        end

        // Non-data frames are filtered; only the data frame yields a result.
        got_q.delete();
        send_beat(mk(8'h0b), 8'hff, TUSER_SOT);
        send_beat(mk(8'h05), 8'hff, TUSER_MID);
        send_beat(mk(8'h11), 8'hff, TUSER_EOT);
        send_beat(mk(8'h0b), 8'hff, TUSER_SOT_EOT);
        idle();
        tick();
        chk("nondata_no_result", 64'(len_tvalid), 64'd0);
        chk("nondata_tready", 64'(ob_tready), 64'd1);
        send_beat(mk(8'h05), 8'hff, TUSER_SOT);
        send_beat(mk(8'h00), 8'hff, TUSER_MID);
        send_beat(mk(8'h00), 8'hff, TUSER_EOT);
        idle();
        wait_result();
        tick();
        exp_fc++;
        chk("nondata_result_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) chk("nondata_result", 64'(got_q[0]), {31'd0, 1'b0, 32'd16});

        // Backpressure: result held, next header stalled but not dropped.
        len_tready = 1'b0;
        send_beat(mk(8'h05), 8'hff, TUSER_SOT);
        send_beat(mk(8'h00), 8'hff, TUSER_EOT);
        ob_tvalid = 1'b1; ob_tdata = mk(8'h05); ob_tstrb = 8'hff; ob_tuser = TUSER_SOT;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_tready", i), 64'(ob_tready), 64'd0);
            chk($sformatf("bp%0d_valid", i), 64'(len_tvalid), 64'd1);
            chk($sformatf("bp%0d_len", i), 64'(len_tdata), 64'd8);
            tick();
        end
        len_tready = 1'b1;
        tick();
        exp_fc++;
        chk("bp_release_tready", 64'(ob_tready), 64'd1);
        chk("bp_release_valid", 64'(len_tvalid), 64'd0);
        send_beat(ob_tdata, 8'hff, TUSER_SOT);
        send_beat(mk(8'h00), 8'h03, TUSER_EOT);
        idle();
        chk("bp_next_len", 64'(len_tdata), 64'd2);
        chk("bp_next_err", 64'(len_err), 64'd0);
        tick();
        exp_fc++;
        chk("bp_frame_cnt", 64'(frame_cnt), 64'(exp_fc));

        // Restart inside a data frame.
        send_beat(mk(8'h05), 8'hff, TUSER_SOT);
        send_beat(mk(8'h00), 8'hff, TUSER_MID);
        send_beat(mk(8'h00), 8'hff, TUSER_MID);
        send_beat(mk(8'h05), 8'hff, TUSER_SOT);
        send_beat(mk(8'h00), 8'h03, TUSER_EOT);
        idle();
        chk("restart_len", 64'(len_tdata), 64'd2);
        chk("restart_err", 64'(len_err), 64'd1);
        chk("restart_sat_err", 64'(s_len_err), 64'd1);
        tick();
        exp_fc++;

        // Zero-length data frame, and SoT-EoT restarting an open frame.
        send_beat(mk(8'h05), 8'hff, TUSER_SOT_EOT);
        idle();
        chk("zero_valid", 64'(len_tvalid), 64'd1);
        chk("zero_len", 64'(len_tdata), 64'd0);
        chk("zero_err", 64'(len_err), 64'd0);
        tick();
        exp_fc++;
        send_beat(mk(8'h05), 8'hff, TUSER_SOT);
        send_beat(mk(8'h00), 8'hff, TUSER_MID);
        send_beat(mk(8'h0b), 8'hff, TUSER_SOT_EOT);
        idle();
        chk("se_restart_len", 64'(len_tdata), 64'd0);
        chk("se_restart_err", 64'(len_err), 64'd1);
        tick();
        exp_fc++;
        chk("pre_rst_frame_cnt", 64'(frame_cnt), 64'(exp_fc));

        // Reset mid-frame discards the partial frame and clears frame_cnt.
        send_beat(mk(8'h05), 8'hff, TUSER_SOT);
        for (int i = 0; i < 4; i++) send_beat(mk(8'h00), 8'hff, TUSER_MID);
        idle();
        rst = 1'b1;
        tick();
        chk("midrst_tready", 64'(ob_tready), 64'd0);
        chk("midrst_valid", 64'(len_tvalid), 64'd0);
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        got_q.delete();
        exp_fc = 0;
        tick();
        chk("midrst_tready_back", 64'(ob_tready), 64'd1);
        send_beat(mk(8'h05), 8'hff, TUSER_SOT);
        send_beat(mk(8'h00), 8'hff, TUSER_EOT);
        idle();
        chk("midrst_len", 64'(len_tdata), 64'd8);
        chk("midrst_err", 64'(len_err), 64'd0);
        tick();
        exp_fc++;
        chk("midrst_results", 64'(got_q.size()), 64'd1);
        chk("midrst_frame_cnt_after", 64'(frame_cnt), 64'd1);

        // Random beat stream with random gaps and random result backpressure.
        bq.delete();
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 5))
                0: begin
                    push_beat(8'h05, 8'($urandom), TUSER_SOT);
                    push_mids($urandom_range(0, 5));
                    push_beat(8'($urandom), 8'($urandom), TUSER_EOT);
                end
                1: begin
                    push_beat(8'($urandom_range(6, 255)), 8'($urandom), TUSER_SOT);
                    push_mids($urandom_range(0, 3));
                    push_beat(8'($urandom), 8'($urandom), TUSER_EOT);
                end
                2: push_beat(8'h05, 8'($urandom), TUSER_SOT_EOT);
                3: push_beat(8'($urandom_range(6, 255)), 8'($urandom), TUSER_SOT_EOT);
                4: begin
                    push_beat(8'h05, 8'($urandom), TUSER_SOT);
                    push_mids($urandom_range(0, 3));
                    push_beat(8'($urandom), 8'($urandom), TUSER_SOT);
                    push_mids($urandom_range(0, 3));
                    push_beat(8'($urandom), 8'($urandom), TUSER_EOT);
                end
                default: begin
                    push_mids($urandom_range(1, 2));
                    push_beat(8'($urandom), 8'($urandom), TUSER_EOT);
                end
            endcase
        end
        model();
        got_q.delete();
        rnd_done = 1'b0;
        fork
            begin
                foreach (bq[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        tick();
                    end
                    send_beat(bq[i].d, bq[i].s, bq[i].u);
                end
                idle();
                for (int w = 0; w < 400 && got_q.size() < exp_q.size(); w++) tick();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    len_tready = ($urandom_range(0, 2) != 0);
                    tick();
                end
                len_tready = 1'b1;
            end
        join
        chk("rnd_result_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rnd_result%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        exp_fc = exp_fc + exp_q.size();
        chk("rnd_frame_cnt", 64'(frame_cnt), 64'(exp_fc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
